// File: rtl/seg_scan_if.sv
// seg_scan_if: snooped display bus plus the recovered-frame outputs of seg_scan_decoder.
interface seg_scan_if #(parameter int DIGITS = 4);
  logic start;
  logic [7:0] seg_in;
  logic [DIGITS-1:0] dig_in;
  logic [5*DIGITS-1:0] sym_out;
  logic [DIGITS-1:0] dp_out;
  logic [DIGITS-1:0] err_out;
  logic busy;
  logic frame_done;
  logic timeout;
  modport master (
    output start, seg_in, dig_in,
    input sym_out, dp_out, err_out, busy, frame_done, timeout
  );
  modport slave (
    input start, seg_in, dig_in,
    output sym_out, dp_out, err_out, busy, frame_done, timeout
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers per-digit symbol and dp codes from a multiplexed 7-segment bus,
// one frame per start request, with a stability filter and a capture timeout.
module seg_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int STABLE = 4,
  parameter int TIMEOUT = 65535
) (
  input logic clk,
  input logic rst_n,
  seg_scan_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0, CAPTURE = 1'b1;
  localparam int CW = $clog2(STABLE);
  localparam logic [CW-1:0] CNT_TOP = CW'(STABLE - 1);
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = 6'd0;
      7'b0110000: decode = 6'd1;
      7'b1101101: decode = 6'd2;
      7'b1111001: decode = 6'd3;
      7'b0110011: decode = 6'd4;
      7'b1011011: decode = 6'd5;
      7'b1011111: decode = 6'd6;
      7'b1110000: decode = 6'd7;
      7'b1111111: decode = 6'd8;
      7'b1111011: decode = 6'd9;
      7'b1110111: decode = 6'd10;
      7'b0011111: decode = 6'd11;
      7'b1001110: decode = 6'd12;
      7'b0111101: decode = 6'd13;
      7'b1001111: decode = 6'd14;
      7'b1000111: decode = 6'd15;
      7'b0110111: decode = 6'd16;
      default:    decode = 6'b111111;
    endcase
  endfunction
  logic [7:0] seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic taken_q, taken_d;
  logic [0:0] state_q, state_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  logic [15:0] timer_q, timer_d;
  logic [5*DIGITS-1:0] sym_q, sym_d;
  logic [DIGITS-1:0] dp_q, dp_d, err_q, err_d;
  logic done_q, done_d, to_q, to_d;
  logic same, acc, full;
  logic [DIGITS-1:0] wr;
  logic [5:0] dec;
  always_comb begin
    seg_d = bus.seg_in;
    dig_d = bus.dig_in;
    same = {bus.seg_in, bus.dig_in} == {seg_q, dig_q};
    // a run is taken once, on the edge that sees STABLE+1 identical samples in a row
    acc = same && cnt_q == CNT_TOP && !taken_q && $onehot(dig_q);
    cnt_d = !same ? '0 : cnt_q == CNT_TOP ? cnt_q : cnt_q + 1'b1;
    taken_d = same && (taken_q || acc);
    wr = (state_q == CAPTURE && acc) ? dig_q & ~mask_q : '0;
    full = &(mask_q | wr);
    mask_d = state_q == IDLE ? '0 : mask_q | wr;
    timer_d = state_q == IDLE ? '0 : timer_q + 1'b1;
    done_d = state_q == CAPTURE && full;
    to_d = state_q == CAPTURE && !full && timer_q == 16'(TIMEOUT - 1);
    state_d = state_q == IDLE ? (bus.start ? CAPTURE : IDLE) : (done_d || to_d) ? IDLE : CAPTURE;
    dec = decode(seg_q[7:1]);
    sym_d = sym_q;
    dp_d = dp_q;
    err_d = err_q;
    for (int i = 0; i < DIGITS; i++) begin
      sym_d[5*i +: 5] = wr[i] ? dec[4:0] : sym_q[5*i +: 5];
      dp_d[i] = wr[i] ? seg_q[0] : dp_q[i];
      err_d[i] = wr[i] ? dec[5] : err_q[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seg_q <= '0;
      dig_q <= '0;
      cnt_q <= '0;
      taken_q <= 1'b0;
      state_q <= IDLE;
      mask_q <= '0;
      timer_q <= '0;
      sym_q <= '0;
      dp_q <= '0;
      err_q <= '0;
      done_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
      cnt_q <= cnt_d;
      taken_q <= taken_d;
      state_q <= state_d;
      mask_q <= mask_d;
      timer_q <= timer_d;
      sym_q <= sym_d;
      dp_q <= dp_d;
      err_q <= err_d;
      done_q <= done_d;
      to_q <= to_d;
    end
  assign bus.sym_out = sym_q;
  assign bus.dp_out = dp_q;
  assign bus.err_out = err_q;
  assign bus.busy = state_q == CAPTURE;
  assign bus.frame_done = done_q;
  assign bus.timeout = to_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: decode-table vectors, hand-written corner sequences and random bus
// traffic, all checked against a run-length based reference model of the snooper.
module tb_seg_scan_decoder;
  localparam int DIGITS = 4, STABLE = 4, TIMEOUT = 100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  seg_scan_if #(.DIGITS(DIGITS)) sif ();
  seg_scan_decoder #(.DIGITS(DIGITS), .STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(sif)
  );
  typedef struct {
    int dig;
    logic [7:0] seg;
    logic [4:0] sym;
    logic dp;
    logic err;
  } vec_t;
  vec_t vecs [20];
  logic [6:0] pat [17] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
                           7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111,
                           7'b1000111, 7'b0110111};
  int checks = 0, failures = 0, fd_cnt = 0, to_cnt = 0;
  logic [7:0] m_seg;
  logic [3:0] m_dig, m_mask, m_dp, m_err;
  logic [19:0] m_sym;
  logic m_busy, m_fd, m_to;
  int m_run, m_cap;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [5:0] ref_decode(input logic [6:0] s);
    for (int k = 0; k < 17; k++) if (pat[k] == s) return {1'b0, 5'(k)};
    return 6'b111111;
  endfunction
  task automatic model_reset();
    m_seg = '0; m_dig = '0; m_run = 0; m_cap = 0; m_mask = '0;
    m_sym = '0; m_dp = '0; m_err = '0; m_busy = 0; m_fd = 0; m_to = 0;
  endtask
  // run length counts edges since the sample last changed; a run is taken when it reaches STABLE
  task automatic model_edge();
    logic acc;
    logic [5:0] d;
    m_fd = 0; m_to = 0;
    if ({sif.seg_in, sif.dig_in} != {m_seg, m_dig}) begin
      m_seg = sif.seg_in; m_dig = sif.dig_in; m_run = 0;
    end else m_run++;
    acc = m_run == STABLE && $countones(m_dig) == 1;
    if (m_busy) begin
      m_cap++;
      d = ref_decode(m_seg[7:1]);
      for (int i = 0; i < DIGITS; i++)
        if (acc && m_dig[i] && !m_mask[i]) begin
          m_sym[5*i +: 5] = d[4:0]; m_dp[i] = m_seg[0]; m_err[i] = d[5]; m_mask[i] = 1'b1;
        end
      if (m_mask == 4'hF) begin m_fd = 1; m_busy = 0; end
      else if (m_cap == TIMEOUT) begin m_to = 1; m_busy = 0; end
    end else if (sif.start) begin
      m_busy = 1; m_mask = '0; m_cap = 0;
    end
  endtask
  task automatic cmp_all();
    chk("sym", 32'(sif.sym_out), 32'(m_sym));
    chk("dp", 32'(sif.dp_out), 32'(m_dp));
    chk("err", 32'(sif.err_out), 32'(m_err));
    chk("busy", 32'(sif.busy), 32'(m_busy));
    chk("frame_done", 32'(sif.frame_done), 32'(m_fd));
    chk("timeout", 32'(sif.timeout), 32'(m_to));
    fd_cnt += int'(sif.frame_done);
    to_cnt += int'(sif.timeout);
  endtask
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cmp_all();
  endtask
  task automatic hold(input int d, input logic [7:0] s, input int n);
    sif.dig_in = 4'(1) << d;
    sif.seg_in = s;
    repeat (n) step();
  endtask
  task automatic start_frame();
    sif.start = 1'b1;
    step();
    sif.start = 1'b0;
  endtask
  task automatic scan1();
    hold(0, 8'b11111100, 10);
    hold(1, 8'b01100001, 10);
    hold(2, 8'b11011010, 10);
    hold(3, 8'b01101110, 10);
  endtask
  task automatic chk_scan1(input string n);
    chk({n, "_sym"}, 32'(sif.sym_out), 32'({5'd16, 5'd2, 5'd1, 5'd0}));
    chk({n, "_dp"}, 32'(sif.dp_out), 32'h2);
    chk({n, "_err"}, 32'(sif.err_out), 32'h0);
    chk({n, "_busy"}, 32'(sif.busy), 32'h0);
    chk({n, "_fd_cnt"}, 32'(fd_cnt), 32'd1);
  endtask
  initial begin
    int first_to;
    vecs = '{
      '{0, 8'b11111100, 5'd0, 1'b0, 1'b0}, '{1, 8'b01100001, 5'd1, 1'b1, 1'b0},
      '{2, 8'b11011010, 5'd2, 1'b0, 1'b0}, '{3, 8'b11110011, 5'd3, 1'b1, 1'b0},
      '{0, 8'b01100110, 5'd4, 1'b0, 1'b0}, '{1, 8'b10110111, 5'd5, 1'b1, 1'b0},
      '{2, 8'b10111110, 5'd6, 1'b0, 1'b0}, '{3, 8'b11100000, 5'd7, 1'b0, 1'b0},
      '{0, 8'b11111111, 5'd8, 1'b1, 1'b0}, '{1, 8'b11110110, 5'd9, 1'b0, 1'b0},
      '{2, 8'b11101110, 5'd10, 1'b0, 1'b0}, '{3, 8'b00111111, 5'd11, 1'b1, 1'b0},
      '{0, 8'b10011100, 5'd12, 1'b0, 1'b0}, '{1, 8'b01111010, 5'd13, 1'b0, 1'b0},
      '{2, 8'b10011111, 5'd14, 1'b1, 1'b0}, '{3, 8'b10001110, 5'd15, 1'b0, 1'b0},
      '{0, 8'b01101110, 5'd16, 1'b0, 1'b0}, '{1, 8'b00000001, 5'd31, 1'b1, 1'b1},
      '{2, 8'b10101010, 5'd31, 1'b0, 1'b1}, '{3, 8'b11111101, 5'd0, 1'b1, 1'b0}
    };
    sif.start = 1'b0; sif.seg_in = '0; sif.dig_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_sym", 32'(sif.sym_out), 32'h0);
    chk("rst_flags", 32'({sif.dp_out, sif.err_out, sif.busy, sif.frame_done, sif.timeout}), 32'h0);
    rst_n = 1'b1;
    step();
    // decode table, four records per frame
    for (int g = 0; g < 5; g++) begin
      fd_cnt = 0;
      start_frame();
      chk("tbl_busy", 32'(sif.busy), 32'h1);
      for (int j = 0; j < 4; j++) hold(vecs[4*g+j].dig, vecs[4*g+j].seg, 6);
      for (int j = 0; j < 4; j++) begin
        chk("tbl_sym", 32'(sif.sym_out[5*vecs[4*g+j].dig +: 5]), 32'(vecs[4*g+j].sym));
        chk("tbl_dp", 32'(sif.dp_out[vecs[4*g+j].dig]), 32'(vecs[4*g+j].dp));
        chk("tbl_err", 32'(sif.err_out[vecs[4*g+j].dig]), 32'(vecs[4*g+j].err));
      end
      chk("tbl_fd_cnt", 32'(fd_cnt), 32'd1);
    end
    // glitch filter: 3-cycle pattern ignored, 4-cycle pattern written on its 4th edge
    fd_cnt = 0;
    start_frame();
    hold(0, 8'b11110010, 3);
    hold(0, 8'b00000000, 0);
    sif.dig_in = '0;
    repeat (2) step();
    chk("glitch_ignored", 32'(sif.sym_out[4:0]), 32'd16);
    hold(0, 8'b11100000, 4);
    chk("glitch_early", 32'(sif.sym_out[4:0]), 32'd16);
    step();
    chk("glitch_written", 32'(sif.sym_out[4:0]), 32'd7);
    repeat (2) step();
    hold(1, 8'b01100000, 6);
    hold(2, 8'b10101010, 6);
    chk("unk_sym", 32'(sif.sym_out[14:10]), 32'd31);
    chk("unk_dp", 32'(sif.dp_out[2]), 32'd0);
    chk("unk_err", 32'(sif.err_out[2]), 32'd1);
    hold(3, 8'b11111110, 6);
    chk("glitch_fd_cnt", 32'(fd_cnt), 32'd1);
    // two-hot digit enable is never accepted
    fd_cnt = 0;
    start_frame();
    sif.dig_in = 4'b0011; sif.seg_in = 8'b11111100;
    repeat (20) step();
    chk("twohot_sym", 32'(sif.sym_out), 32'({5'd8, 5'd31, 5'd1, 5'd7}));
    chk("twohot_err", 32'(sif.err_out), 32'h4);
    chk("twohot_busy", 32'(sif.busy), 32'h1);
    scan1();
    chk_scan1("twohot");
    // timeout with only digits 0 and 1 driven
    fd_cnt = 0; to_cnt = 0; first_to = 0;
    start_frame();
    for (int k = 1; k <= 105; k++) begin
      if (k == 1) begin sif.dig_in = 4'b0001; sif.seg_in = 8'b10110110; end
      if (k == 11) begin sif.dig_in = 4'b0010; sif.seg_in = 8'b10111110; end
      if (k == 21) begin sif.dig_in = 4'b0000; sif.seg_in = 8'h00; end
      step();
      if (sif.timeout && first_to == 0) first_to = k;
    end
    chk("to_cycle", 32'(first_to), 32'd100);
    chk("to_sym", 32'(sif.sym_out), 32'({5'd16, 5'd2, 5'd6, 5'd5}));
    chk("to_cnt", 32'(to_cnt), 32'd1);
    chk("to_fd_cnt", 32'(fd_cnt), 32'd0);
    chk("to_busy", 32'(sif.busy), 32'd0);
    // asynchronous reset mid-capture
    start_frame();
    hold(0, 8'b11110110, 6);
    hold(1, 8'b11101110, 6);
    chk("pre_rst_busy", 32'(sif.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sym", 32'(sif.sym_out), 32'h0);
    chk("arst_flags", 32'({sif.dp_out, sif.err_out, sif.busy, sif.frame_done, sif.timeout}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    fd_cnt = 0; to_cnt = 0;
    sif.dig_in = '0;
    repeat (3) step();
    chk("post_rst_pulses", 32'(fd_cnt + to_cnt), 32'd0);
    start_frame();
    scan1();
    chk_scan1("post_rst");
    // random traffic against the model
    for (int r = 0; r < 500; r++) begin
      int d = $urandom_range(0, 9);
      int s = $urandom_range(0, 20);
      int len = $urandom_range(1, 8);
      sif.dig_in = d < 8 ? 4'(1) << (d % 4) : 4'($urandom);
      sif.seg_in = s < 17 ? {pat[s], 1'($urandom)} : 8'($urandom);
      for (int k = 0; k < len; k++) begin
        sif.start = $urandom_range(0, 11) == 0;
        step();
      end
      sif.start = 1'b0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reverse path of the 7-segment encoder. Snoops a multiplexed display bus (segment pattern plus one-hot digit enable) and recovers, for each digit, the 5-bit symbol code and the dp bit.
- Captures one frame per start request, using a stability filter and a timeout.
- Sits beside the display driver for self-check and for readback of the displayed value.

Parameters:
- DIGITS, 4, number of multiplexed digits on the bus (2..8).
- STABLE, 4, consecutive identical samples needed to accept a pattern (>=2).
- TIMEOUT, 65535, maximum capture cycles before the frame is abandoned (fits in 16 bits).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to capture a frame.
- seg_in  in  8  bus pattern. [7]=a, [6]=b, [5]=c, [4]=d, [3]=e, [2]=f, [1]=g, [0]=dp. Active high.
- dig_in  in  DIGITS  digit enable, one-hot, active high.
- sym_out  out  5*DIGITS  recovered symbol per digit; digit i occupies [5i+4:5i].
- dp_out  out  DIGITS  recovered dp per digit.
- err_out  out  DIGITS  1 = last captured pattern for that digit was not in the table.
- busy  out  1  high while in CAPTURE.
- frame_done  out  1  one-cycle pulse when all digits have been captured.
- timeout  out  1  one-cycle pulse when the frame is abandoned.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: sym_out=0, dp_out=0, err_out=0, busy=0, frame_done=0, timeout=0.
  - Internal: state=IDLE, sample registers=0, stability count=0, capture mask=0, timer=0.
  - Assertion mid-capture abandons the frame. No pulses are emitted.
- Input stage: seg_in and dig_in are registered every cycle (sample). The decoder uses the sample only.
- Stability filter:
  - cnt resets to 0 when the new sample differs from the previous one.
  - cnt increments, saturating at STABLE-1, when the sample is equal.
  - A sample is accepted on the edge where the sample is equal and cnt==STABLE-1, and only if the taken flag is clear. Acceptance sets taken.
  - taken clears on any sample change.
  - Each stable run is accepted at most once.
- Invalid digit enable: a sample whose dig is zero or has more than one bit set is never accepted. cnt still tracks it.
- Latency: if the bus changes before edge 0 and then holds, the sample updates at edge 0 and acceptance (register write) occurs at edge STABLE.
- Decode table. Segments abcdefg map to a symbol, dp passes straight through:

  | Symbol | abcdefg | Symbol | abcdefg |
  |---|---|---|---|
  | 0 | 1111110 | 9 | 1111011 |
  | 1 | 0110000 | A(10) | 1110111 |
  | 2 | 1101101 | b(11) | 0011111 |
  | 3 | 1111001 | C(12) | 1001110 |
  | 4 | 0110011 | d(13) | 0111101 |
  | 5 | 1011011 | E(14) | 1001111 |
  | 6 | 1011111 | F(15) | 1000111 |
  | 7 | 1110000 | H(16) | 0110111 |
  | 8 | 1111111 | | |

  - Any other pattern gives symbol 5'b11111 and err=1. A table hit gives err=0.
- State machine:
  - IDLE: start=1 clears the mask and timer, goes to CAPTURE, and busy=1 from the next cycle.
  - CAPTURE:
    - Timer increments every cycle.
    - An accepted sample for digit i with mask[i]=0 writes sym/dp/err for digit i and sets mask[i].
    - An accepted sample for a digit already in the mask is ignored (first capture wins).
    - When the mask becomes all ones: frame_done pulses for the cycle after the final write edge, then IDLE.
    - When the timer reaches TIMEOUT-1 without completion: timeout pulses, then IDLE. Digits already captured keep their new values; the rest keep their old values.
    - Completion and timeout on the same edge: completion wins, with no timeout pulse.
    - start is ignored in CAPTURE.
  - start in the same cycle as a frame_done or timeout exit is ignored (the FSM is not yet in IDLE).
- Outputs are only written during CAPTURE. In IDLE they hold the last frame.

Test Plan:
1. DIGITS=4, STABLE=4. Start, then drive dig=0001/seg=8'b11111100, 0010/8'b01100001, 0100/8'b11011010, 1000/8'b01101110, each for 10 cycles -> sym_out={16,2,1,0}, dp_out=4'b0010, err_out=0, one frame_done pulse, busy falls.
2. Glitch filter: a pattern held for 3 cycles then changed -> no write. Held for 4 cycles -> write occurs exactly at the 4th edge after the sample updates.
3. Unknown pattern 8'b10101010 on digit 2 -> sym_out[14:10]=5'b11111, dp_out[2]=0, err_out[2]=1.
4. dig=0011 held for 20 cycles during CAPTURE -> no writes, mask unchanged. Then the valid scan from scenario 1 completes the frame.
5. TIMEOUT=100, only digits 0 and 1 driven -> timeout pulse at cycle 100, digits 0 and 1 updated, digits 2 and 3 retain their old values, no frame_done.
6. rst_n pulled low while busy after 2 digits are captured -> all outputs 0 immediately, with no pulses. A later start captures a fresh full frame.
